seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, handshaked successor to the single-cycle datapath ALU: executes the existing ADD/SUB/AND/OR/SLT operations plus SLTU, iterative unsigned multiply and unsigned divide/remainder. It sits between the operand-fetch stage and writeback of the RISC-V core. Results are registered and held behind a valid/ready handshake, so multi-cycle operations can stall the pipeline.

## Interface
- `WIDTH`, default 32: operand and result width; must be ≥ 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operands and op are presented.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `op`  in  4  operation code, listed under Operation.
- `src_a`, `src_b`  in  WIDTH  operands.
- `out_valid`  out  1  `result`, `zero` and `illegal` are valid.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  WIDTH  operation result.
- `zero`  out  1  high when `result` == 0.
- `illegal`  out  1  high when the accepted op was not a defined code.

## Operation
- Op codes:
  - 0000 ADD: a+b, mod 2^WIDTH.
  - 0001 SUB: a−b, mod 2^WIDTH.
  - 0010 AND.
  - 0011 OR.
  - 0101 SLT: signed a<b gives 1, else 0.
  - 0110 SLTU: unsigned a<b.
  - 1000 MUL: low WIDTH bits of a×b.
  - 1001 MULHU: high WIDTH bits of unsigned a×b.
  - 1100 DIVU: unsigned quotient.
  - 1101 REMU: unsigned remainder.
  - All other codes: `result`=0, `illegal`=1, single-cycle path.
- Accept: `in_valid && in_ready` at a rising edge. Operands and op are latched at that edge; later input changes are ignored.
- FSM states: IDLE, BUSY, DONE.
  - IDLE → DONE on accepting a single-cycle op, with the result computed and registered at the accept edge.
  - IDLE → BUSY on accepting MUL, MULHU, DIVU or REMU. An iteration counter loads WIDTH−1.
  - BUSY: one shift-add step (multiply) or one restoring subtract-shift step (divide) per cycle. Counter decrements each cycle. At count 0 the final step executes and the state moves to DONE.
  - DONE: `out_valid`=1. Move to IDLE when `out_ready`=1; otherwise hold `result`, `zero` and `illegal` stable.
- Multiplier: 2×WIDTH-bit product register, LSB-first over b.
- Divider: restoring, MSB-first over a, with a WIDTH+1-bit partial remainder.
- Divide by zero: DIVU returns all ones and REMU returns a. It is not flagged illegal and still takes the full iteration count.
- `zero` is computed from the final registered `result`. It is 0 whenever `out_valid`=0.
- No accept in BUSY or DONE (`in_ready`=0). A new op issued in the DONE-drain cycle is accepted on the following cycle.

## Timing
- Reset (asynchronous assert, synchronous-safe release) puts the FSM in IDLE with the following output values:
  - `in_ready`=1, `out_valid`=0.
  - `result`=0, `zero`=0, `illegal`=0.
  - Counter and the internal product/remainder registers = 0.
- Reset mid-BUSY or mid-DONE aborts the operation immediately. No partial result is ever presented.
- Single-cycle op: accept at edge k; `out_valid`=1 after edge k.
- Multi-cycle op: accept at edge k; BUSY for WIDTH cycles; `out_valid`=1 after edge k+WIDTH. Latency is identical for all multi-cycle ops and for any operand values.
- With `out_ready` held at 1, the earliest next accept is at edge k+2 (single-cycle) or k+WIDTH+2 (multi-cycle).
- `in_ready` and `out_valid` are registered-state decodes, with no combinational path from `in_valid` or `out_ready`.

## Test plan
- Reset and single-cycle ops, WIDTH=32:
  - Deassert `rst_n` mid-run → all outputs at reset values.
  - ADD 0xFFFFFFFF+1 → `result`=0, `zero`=1, one cycle after accept.
  - SUB 5−7 → `result`=0xFFFFFFFE.
- Compares: SLT 0xFFFFFFFF vs 1 → 1. SLTU with the same operands → 0. Undefined op 0111 → `result`=0, `illegal`=1, `zero`=1.
- Multiply:
  - MUL 0x12345678 × 0x9ABCDEF0 → 0x242D2080.
  - MULHU with the same operands → 0x0B00EA4E.
  - `out_valid` exactly 32 cycles after accept in both cases.
- Divide:
  - DIVU 100/7 → 14; REMU 100/7 → 2.
  - DIVU x/0 → 0xFFFFFFFF; REMU 0x55/0 → 0x55.
- Backpressure:
  - Hold `out_ready`=0 for 10 cycles after DONE → `result` stable and `in_ready`=0 throughout. Releasing `out_ready` returns to IDLE.
  - Back-to-back ADDs with `out_ready`=1 → accepts every 2 cycles.
- Reset aborts: assert `rst_n`=0 during BUSY cycle 10 of a DIVU → IDLE with `out_valid`=0. A following ADD 2+3 returns 5 with correct latency.

Source files
------------

// File: rtl/seq_alu_if.sv
// Handshake bundle between operand fetch, the sequential ALU and writeback.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;

  modport master (
    output in_valid, op, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  modport slave (
    input  in_valid, op, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops plus iterative unsigned
// multiply (shift-add, LSB-first) and divide (restoring, MSB-first).
// Results are registered and held until the consumer takes them.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      rst_n,
  seq_alu_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state, state_d;
  logic [CW-1:0]        cnt;
  logic [3:0]           op_q;
  logic [WIDTH-1:0]     a_q, b_q, quo, res_q;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH:0]       rem;
  logic                 ill_q;

  logic                 accept, multi;
  logic [WIDTH-1:0]     sc_res;
  logic                 sc_ill;
  logic [WIDTH:0]       mul_sum, div_sh, div_diff, rem_nx;
  logic [2*WIDTH-1:0]   prod_nx;
  logic [WIDTH-1:0]     quo_nx, fin_res;

  assign accept = bus.in_valid && (state == IDLE);
  assign multi  = (bus.op == 4'b1000) || (bus.op == 4'b1001) ||
                  (bus.op == 4'b1100) || (bus.op == 4'b1101);

  // Single-cycle result and illegal-op decode straight off the inputs.
  always_comb begin
    sc_res = '0;
    sc_ill = 1'b0;
    case (bus.op)
      4'b0000: sc_res = bus.src_a + bus.src_b;
      4'b0001: sc_res = bus.src_a - bus.src_b;
      4'b0010: sc_res = bus.src_a & bus.src_b;
      4'b0011: sc_res = bus.src_a | bus.src_b;
      4'b0101: sc_res = WIDTH'($signed(bus.src_a) < $signed(bus.src_b));
      4'b0110: sc_res = WIDTH'(bus.src_a < bus.src_b);
      4'b1000, 4'b1001, 4'b1100, 4'b1101: sc_res = '0;
      default: sc_ill = 1'b1;
    endcase
  end

  // One iteration of each engine; the final-step value feeds the result
  // register directly so the answer lands on the same edge as BUSY->DONE.
  always_comb begin
    mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a_q} : '0);
    prod_nx  = {mul_sum, prod[WIDTH-1:1]};
    div_sh   = {rem[WIDTH-1:0], quo[WIDTH-1]};
    div_diff = div_sh - {1'b0, b_q};
    // Divide by zero never borrows: quotient fills with ones, remainder
    // accumulates the dividend, which is exactly the defined result.
    rem_nx   = div_diff[WIDTH] ? div_sh : div_diff;
    quo_nx   = {quo[WIDTH-2:0], ~div_diff[WIDTH]};
    case (op_q)
      4'b1000: fin_res = prod_nx[WIDTH-1:0];
      4'b1001: fin_res = prod_nx[2*WIDTH-1:WIDTH];
      4'b1100: fin_res = quo_nx;
      default: fin_res = rem_nx[WIDTH-1:0];
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (accept) state_d = multi ? BUSY : DONE;
      BUSY: if (cnt == '0) state_d = DONE;
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Operand latch, iteration engines and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      quo   <= '0;
      prod  <= '0;
      rem   <= '0;
      res_q <= '0;
      ill_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q <= bus.op;
          a_q  <= bus.src_a;
          b_q  <= bus.src_b;
          if (multi) begin
            cnt   <= CW'(WIDTH - 1);
            prod  <= {{WIDTH{1'b0}}, bus.src_b};
            rem   <= '0;
            quo   <= bus.src_a;
            ill_q <= 1'b0;
          end else begin
            res_q <= sc_res;
            ill_q <= sc_ill;
          end
        end
        BUSY: begin
          if (op_q[2]) begin
            rem <= rem_nx;
            quo <= quo_nx;
          end else begin
            prod <= prod_nx;
          end
          if (cnt == '0) res_q <= fin_res;
          else           cnt   <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = res_q;
  assign bus.zero      = (state == DONE) && (res_q == '0);
  assign bus.illegal   = ill_q;
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: stimulus pushes expected responses into a
// scoreboard queue; a monitor compares them as the DUT hands results out.
module tb_seq_alu;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  seq_alu_if #(.WIDTH(W)) bus ();
  seq_alu #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         ill;
    int           lat;
    string        name;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   acc_hist[$];
  int   cyc = 0;
  int   npass = 0;
  int   ntot = 0;
  logic ov_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    ntot++;
    if (act === expv) npass++;
    else $display("FAIL %s: got %h, expected %h", name, act, expv);
  endtask

  // Monitor: records accept edges, checks latency on out_valid rise and
  // compares the payload on the handshake cycle.
  always @(negedge clk) begin
    exp_t e;
    int   a;
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready) begin
        acc_q.push_back(cyc + 1);
        acc_hist.push_back(cyc + 1);
      end
      if (bus.out_valid && !ov_prev) begin
        if (exp_q.size() == 0 || acc_q.size() == 0)
          check("spurious out_valid", {31'b0, bus.out_valid}, 32'd0);
        else begin
          a = acc_q.pop_front();
          check({exp_q[0].name, " latency"}, 32'(cyc - a), 32'(exp_q[0].lat));
        end
      end
      if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, " result"}, bus.result, e.res);
        check({e.name, " zero"}, {31'b0, bus.zero}, {31'b0, (e.res == '0)});
        check({e.name, " illegal"}, {31'b0, bus.illegal}, {31'b0, e.ill});
      end
    end
    ov_prev <= bus.out_valid;
  end

  // Present one op, push its expectation, return #1 after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] res, input logic ill, input int lat, input string name);
    bit ok = 0;
    exp_q.push_back('{res: res, ill: ill, lat: lat, name: name});
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.src_a = a;
    bus.src_b = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.src_a = '1;   // later input changes must not matter
    bus.src_b = '1;
    bus.op = 4'b0000;
    if (!ok) check({name, " accept timeout"}, 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    if (!ok) check("drain timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, " in_ready"},  {31'b0, bus.in_ready},  32'd1);
    check({tag, " out_valid"}, {31'b0, bus.out_valid}, 32'd0);
    check({tag, " result"},    bus.result,             32'd0);
    check({tag, " zero"},      {31'b0, bus.zero},      32'd0);
    check({tag, " illegal"},   {31'b0, bus.illegal},   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    bit seen;
    bus.in_valid = 1'b0;
    bus.op = '0;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-cycle ops
    issue(4'b0000, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 0, "ADD wrap");
    issue(4'b0001, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 0, "SUB 5-7");
    issue(4'b0010, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h00F0_F000, 1'b0, 0, "AND");
    issue(4'b0011, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'hFFF0_FFF0, 1'b0, 0, "OR");
    issue(4'b0101, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 0, "SLT -1<1");
    issue(4'b0110, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 0, "SLTU max<1");
    issue(4'b0101, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b0, 0, "SLT 1<-1");
    issue(4'b0110, 32'h1, 32'hFFFF_FFFF, 32'h1, 1'b0, 0, "SLTU 1<max");
    issue(4'b0111, 32'h1234, 32'h5678, 32'h0, 1'b1, 0, "undefined op");
    drain();

    // Multi-cycle ops
    issue(4'b1000, 32'h1234_5678, 32'h9ABC_DEF0, 32'h242D_2080, 1'b0, W, "MUL");
    issue(4'b1001, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E, 1'b0, W, "MULHU");
    issue(4'b1100, 32'd100, 32'd7, 32'd14, 1'b0, W, "DIVU 100/7");
    issue(4'b1101, 32'd100, 32'd7, 32'd2, 1'b0, W, "REMU 100/7");
    issue(4'b1100, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1'b0, W, "DIVU x/0");
    issue(4'b1101, 32'h55, 32'd0, 32'h55, 1'b0, W, "REMU 0x55/0");
    drain();

    // Backpressure: hold the result for 10 cycles
    bus.out_ready = 1'b0;
    issue(4'b0000, 32'h11, 32'h22, 32'h33, 1'b0, 0, "ADD held");
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin seen = 1; break; end
    end
    check("held out_valid seen", {31'b0, seen}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("held result", bus.result, 32'h33);
      check("held in_ready", {31'b0, bus.in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    drain();
    @(negedge clk);
    check("released in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;

    // Back-to-back accepts every 2 cycles
    n0 = acc_hist.size();
    issue(4'b0000, 32'd1, 32'd1, 32'd2, 1'b0, 0, "B2B ADD0");
    issue(4'b0000, 32'd2, 32'd2, 32'd4, 1'b0, 0, "B2B ADD1");
    issue(4'b0000, 32'd3, 32'd3, 32'd6, 1'b0, 0, "B2B ADD2");
    drain();
    if (acc_hist.size() >= n0 + 3) begin
      check("B2B spacing 0-1", 32'(acc_hist[n0+1] - acc_hist[n0]), 32'd2);
      check("B2B spacing 1-2", 32'(acc_hist[n0+2] - acc_hist[n0+1]), 32'd2);
    end else
      check("B2B accept count", 32'(acc_hist.size() - n0), 32'd3);

    // Reset in BUSY cycle 10 of a DIVU aborts it
    issue(4'b1100, 32'd1000, 32'd3, 32'd333, 1'b0, W, "DIVU aborted");
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    exp_q.delete();
    acc_q.delete();
    check_reset_outs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(4'b0000, 32'd2, 32'd3, 32'd5, 1'b0, 0, "ADD after abort");
    drain();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
